// File: rtl/cordic_ci_issuer.sv
// Initiator-side sequencer for the multicycle cosine custom-instruction slave:
// queues operands, issues them one at a time, captures results onto a valid/ready port.
module cordic_ci_issuer #(
    parameter int DEPTH   = 8,
    parameter int TIMEOUT = 15
) (
    input  logic        clock,
    input  logic        aclr,
    input  logic        in_valid,
    input  logic [31:0] in_data,
    output logic        in_ready,
    output logic        ci_aclr,
    output logic        ci_clk_en,
    output logic        ci_start,
    output logic [31:0] ci_dataa,
    input  logic [31:0] ci_result,
    input  logic        ci_done,
    output logic        out_valid,
    output logic [31:0] out_data,
    input  logic        out_ready,
    output logic        busy,
    output logic        timeout_err,
    output logic [15:0] done_count
);

    localparam int         AW        = $clog2(DEPTH);
    localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);
    localparam logic [AW:0] PTR_ONE  = {{AW{1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT
    } state_t;

    state_t      state;
    state_t      state_next;

    logic [31:0] mem [DEPTH];
    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    logic        full;
    logic        empty;
    logic        push;
    logic        pop;
    logic        capture;
    logic        abort;
    logic        abort_pulse;
    logic [7:0]  wait_cnt;

    // Extra wrap bit distinguishes full from empty when the index bits match.
    assign empty    = (wr_ptr == rd_ptr);
    assign full     = (wr_ptr[AW] != rd_ptr[AW]) &&
                      (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign in_ready = !full;
    assign push     = in_valid && !full;
    assign ci_aclr  = aclr || abort_pulse;

    always_ff @(posedge clock) begin
        if (aclr) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        pop        = 1'b0;
        capture    = 1'b0;
        abort      = 1'b0;
        ci_start   = 1'b0;
        ci_clk_en  = 1'b0;
        busy       = 1'b0;
        case (state)
            S_IDLE: begin
                // A pending result must be leaving this cycle before another issue.
                if (!empty && (!out_valid || out_ready)) begin
                    pop        = 1'b1;
                    state_next = S_ISSUE;
                end
            end
            S_ISSUE: begin
                ci_start   = 1'b1;
                ci_clk_en  = 1'b1;
                busy       = 1'b1;
                state_next = S_WAIT;
            end
            S_WAIT: begin
                ci_clk_en = 1'b1;
                busy      = 1'b1;
                if (ci_done) begin
                    capture    = 1'b1;
                    state_next = S_IDLE;
                end else if (wait_cnt == WAIT_LAST) begin
                    abort      = 1'b1;
                    state_next = S_IDLE;
                end
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (aclr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (push) begin
            mem[wr_ptr[AW-1:0]] <= in_data;
        end
    end

    always_ff @(posedge clock) begin
        if (aclr) begin
            ci_dataa    <= '0;
            wait_cnt    <= '0;
            abort_pulse <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            if (pop) begin
                ci_dataa <= mem[rd_ptr[AW-1:0]];
            end
            if (pop) begin
                wait_cnt <= '0;
            end else if (state == S_WAIT) begin
                wait_cnt <= wait_cnt + 8'd1;
            end
            abort_pulse <= abort;
            if (abort) begin
                timeout_err <= 1'b1;
            end
        end
    end

    // Capture takes priority over the consumer draining the previous result.
    always_ff @(posedge clock) begin
        if (aclr) begin
            out_valid  <= 1'b0;
            out_data   <= '0;
            done_count <= '0;
        end else begin
            if (capture) begin
                out_valid  <= 1'b1;
                out_data   <= ci_result;
                done_count <= done_count + 16'd1;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule
